// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the four-master system bus arbiter.
// Holds the master count, owner indices, FSM state encodings and the hold limit default.
package bus_rr_arbiter_pkg;

  localparam int N_MASTERS    = 4;
  localparam int OWNER_W      = 2;
  localparam int HOLD_CNT_W   = 8;
  localparam int MAX_HOLD_DEF = 16;

  localparam logic [OWNER_W-1:0] OWN_CPU_IF  = 2'd0;
  localparam logic [OWNER_W-1:0] OWN_CPU_MEM = 2'd1;
  localparam logic [OWNER_W-1:0] OWN_MST2    = 2'd2;
  localparam logic [OWNER_W-1:0] OWN_MST3    = 2'd3;

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  function automatic logic [N_MASTERS-1:0] owner_onehot(input logic [OWNER_W-1:0] idx);
    owner_onehot      = '0;
    owner_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first set bit of req_mask searching
// start, start+1, start+2, start+3 (mod 4).
module rr_pick4
  import bus_rr_arbiter_pkg::*;
(
  input  logic [N_MASTERS-1:0] req_mask,
  input  logic [OWNER_W-1:0]   start,
  output logic [OWNER_W-1:0]   win,
  output logic                 valid
);

  logic [OWNER_W-1:0] idx;

  // Walk from lowest priority to highest so the last hit is the winner.
  always_comb begin
    win   = start;
    valid = 1'b0;
    idx   = start;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      idx = start + OWNER_W'(i);
      if (req_mask[idx]) begin
        win   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared system bus with active-low request/grant.
// Optional hold-timeout watchdog is built when BUS_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// PARK  | owner is not requesting; arbitrate every cycle
// HOLD  | owner is requesting; keep the bus until release (or timeout)
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req_,
  output logic [N_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]   owner,
  output logic                 arb_switch,
  output logic                 timeout_err
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_rr_arbiter: MAX_HOLD must be within 2..255");
  end

  arb_state_e          state, state_nxt;
  logic [OWNER_W-1:0]  owner_nxt;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] pick_mask;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_valid;
  logic                owner_req;
  logic                timeout_hit;

  assign req       = ~req_;
  assign owner_req = req[owner];
  assign grnt_     = ~owner_onehot(owner);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [N_MASTERS-1:0]  others;
  logic                  others_req;

  assign others      = req & ~owner_onehot(owner);
  assign others_req  = |others;
  assign timeout_hit = (state == ST_HOLD) && owner_req && others_req &&
                       (hold_cnt == HOLD_CNT_W'(MAX_HOLD));
  // On timeout the current owner is masked out; it re-wins only by rotation later.
  assign pick_mask   = timeout_hit ? others : req;
  assign hold_cnt_nxt = ((state == ST_HOLD) && owner_req && others_req && !timeout_hit)
                        ? hold_cnt + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      hold_cnt    <= hold_cnt_nxt;
      timeout_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign pick_mask   = req;
  assign timeout_err = 1'b0;
`endif

  rr_pick4 u_pick (
    .req_mask (pick_mask),
    .start    (owner + 1'b1),
    .win      (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if ((state == ST_HOLD) && owner_req && !timeout_hit) begin
      state_nxt = ST_HOLD;
    end else if (pick_valid) begin
      owner_nxt = pick_idx;
      state_nxt = ST_HOLD;
    end else begin
      state_nxt = ST_PARK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_PARK;
      owner      <= OWN_CPU_IF;
      arb_switch <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      arb_switch <= (owner_nxt != owner);
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: per-cycle scoreboard against a behavioural model.
// Timeout expectations follow BUS_ARB_TIMEOUT_EN as compiled.
module tb_bus_rr_arbiter;

  localparam int MAX_HOLD_TB = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req_;
  logic [3:0] grnt_;
  logic [1:0] owner;
  logic       arb_switch;
  logic       timeout_err;

  typedef struct packed {
    logic [1:0] owner;
    logic [3:0] grnt;
    logic       sw;
    logic       terr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_owner = 0;
  bit m_hold  = 1'b0;
  int m_cnt   = 0;

  bus_rr_arbiter #(.MAX_HOLD(MAX_HOLD_TB)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_        (req_),
    .grnt_       (grnt_),
    .owner       (owner),
    .arb_switch  (arb_switch),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [3:0] grant_of(input int idx);
    logic [3:0] g;
    g      = 4'b1111;
    g[idx] = 1'b0;
    return g;
  endfunction

  // Drive one cycle of requests, predict the post-edge outputs, compare after the edge.
  task automatic drive_cycle(input logic [3:0] r, input string tag);
    logic [3:0] act;
    bit   owner_req, others, tmo, found;
    int   new_owner, idx;
    exp_t e, got;
    @(negedge clk);
    req_ = r;
    act  = ~r;
    owner_req = act[m_owner];
    others = 1'b0;
    for (int j = 0; j < 4; j++) if (j != m_owner && act[j]) others = 1'b1;
    tmo = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    tmo = m_hold && owner_req && others && (m_cnt == MAX_HOLD_TB);
`endif
    new_owner = m_owner;
    found = 1'b0;
    if (m_hold && owner_req && !tmo) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_owner + k) % 4;
        if (!found && act[idx] && !(tmo && idx == m_owner)) begin
          new_owner = idx;
          found = 1'b1;
        end
      end
    end
`ifdef BUS_ARB_TIMEOUT_EN
    m_cnt = (m_hold && owner_req && others && !tmo) ? m_cnt + 1 : 0;
`endif
    e.owner = 2'(new_owner);
    e.grnt  = grant_of(new_owner);
    e.sw    = (new_owner != m_owner);
    e.terr  = tmo;
    sb_q.push_back(e);
    m_owner = new_owner;
    m_hold  = found;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e   = sb_q.pop_front();
      got = {owner, grnt_, arb_switch, timeout_err};
      chk({tag, ".owner"}, 32'(got.owner), 32'(e.owner));
      chk({tag, ".grnt"},  32'(got.grnt),  32'(e.grnt));
      chk({tag, ".sw"},    32'(got.sw),    32'(e.sw));
      chk({tag, ".terr"},  32'(got.terr),  32'(e.terr));
      chk({tag, ".onehot"}, 32'($countones(~grnt_)), 32'd1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".grnt"},  32'(grnt_), 32'h0000_000E);
    chk({tag, ".owner"}, 32'(owner), 32'd0);
    chk({tag, ".sw"},    32'(arb_switch), 32'd0);
    chk({tag, ".terr"},  32'(timeout_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    req_  = 4'b1111;
    #1;
    check_reset_state("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_state("rst_during");
    end
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(4'b1111, "rst_after");
    drive_cycle(4'b1111, "idle");

    // single request from idle, then release leaves the bus parked on master 2
    drive_cycle(4'b1011, "single_req");
    drive_cycle(4'b1011, "single_hold");
    drive_cycle(4'b1111, "single_park");
    drive_cycle(4'b1111, "single_park2");

    // rotation: owner 1 holds, 0/2/3 waiting, release chain 2 -> 3 -> 0
    drive_cycle(4'b1101, "rot_get1");
    drive_cycle(4'b0000, "rot_all");
    drive_cycle(4'b0010, "rot_to2");
    drive_cycle(4'b0110, "rot_to3");
    drive_cycle(4'b1110, "rot_to0");
    drive_cycle(4'b1111, "rot_park");

    // contention while master 0 holds and master 3 waits
    drive_cycle(4'b1110, "cont_hold0");
    for (int i = 0; i < 10; i++) drive_cycle(4'b0110, "cont_wait");
    drive_cycle(4'b0111, "cont_to3");
    drive_cycle(4'b1111, "cont_park");

    // watchdog: master 1 holds while master 2 waits
    drive_cycle(4'b1101, "tmo_get1");
    for (int i = 0; i < 7; i++) drive_cycle(4'b1001, "tmo_wait");
    drive_cycle(4'b1111, "tmo_park");

    // asynchronous reset in the middle of a transfer owned by master 3
    drive_cycle(4'b0111, "ar_get3");
    drive_cycle(4'b0111, "ar_hold3");
    drive_cycle(4'b0011, "ar_cnt");
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("ar_midcycle");
    @(posedge clk);
    #1;
    check_reset_state("ar_held");
    @(negedge clk);
    reset   = 1'b1;
    req_    = 4'b1111;
    m_owner = 0;
    m_hold  = 1'b0;
    m_cnt   = 0;
    drive_cycle(4'b1111, "ar_after");
    drive_cycle(4'b0111, "ar_req3");
    drive_cycle(4'b0011, "ar_post1");
    drive_cycle(4'b0011, "ar_post2");
    drive_cycle(4'b0011, "ar_post3");
    drive_cycle(4'b0011, "ar_post4");
    drive_cycle(4'b0011, "ar_post5");
    drive_cycle(4'b1111, "ar_park");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
